// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
// Central stall generator for the five-stage pipeline. It produces the 6-bit
// stall vector that freezes the PC, IF_ID, ID_EX, EX_MEM, MEM_WB and WB registers.
// It detects load-use hazards between ID and EX. It sequences multi-cycle EX
// operations (mult/div) through a small latency FSM. It merges memory wait
// requests and keeps a saturating count of stalled cycles.
// MC_LATENCY must be at least 2.
module pipeline_stall_ctrl #(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_reg1_rd,
    input  logic [4:0]       id_reg1_addr,
    input  logic             id_reg2_rd,
    input  logic [4:0]       id_reg2_addr,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_wrAddr,
    input  logic             ex_mc_start,
    input  logic             mem_stall_req,
    output logic [5:0]       stall,
    output logic             ex_mc_busy,
    output logic             ex_mc_done,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int             CW       = $clog2(MC_LATENCY);
    // BUSY is entered one cycle after the op arrives in EX and the last
    // BUSY cycle is the one with cnt==1, so the load value is MC_LATENCY-2.
    localparam logic [CW-1:0]  CNT_LOAD = CW'(MC_LATENCY - 2);

    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_LU   = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic [CNT_W-1:0]   stall_cycles_reg;

    logic [1:0]         src_rd;
    logic [4:0]         src_addr [2];
    logic [1:0]         src_match;
    logic               load_use;
    logic               ex_hold;
    logic [5:0]         stall_next;

    // The two ID source operands are handled identically.
    assign src_rd      = {id_reg2_rd, id_reg1_rd};
    assign src_addr[0] = id_reg1_addr;
    assign src_addr[1] = id_reg2_addr;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_match[gi] = src_rd[gi] && (src_addr[gi] == ex_wrAddr);
        end
    endgenerate

    // A load writing r0 never produces a hazard, because r0 is hardwired to zero.
    assign load_use = ex_is_load && (ex_wrAddr != 5'd0) && (|src_match);

    // EX is held on the first cycle of a multi-cycle op and for every BUSY cycle.
    assign ex_hold = ((state_reg == ST_IDLE) && ex_mc_start) || (state_reg == ST_BUSY);

    // Next-state logic. A memory wait freezes the whole sequencer.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (!mem_stall_req) begin
            case (state_reg)
                ST_IDLE: begin
                    if (ex_mc_start) begin
                        if (MC_LATENCY == 2) begin
                            state_next = ST_DONE;
                        end else begin
                            state_next = ST_BUSY;
                            cnt_next   = CNT_LOAD;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt_reg == CW'(1)) begin
                        state_next = ST_DONE;
                    end else begin
                        cnt_next = cnt_reg - CW'(1);
                    end
                end
                // A new op cannot reach EX in the DONE cycle itself, so a start here is ignored.
                ST_DONE: state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Stall vector priority: memory wait, then EX hold, then the load-use bubble.
    always_comb begin
        stall_next = STALL_NONE;
        if (mem_stall_req) begin
            stall_next = STALL_MEM;
        end else if (ex_hold) begin
            stall_next = STALL_EX;
        end else if (load_use) begin
            stall_next = STALL_LU;
        end
    end

    // While in reset, all outputs are quiet regardless of the inputs.
    assign stall        = rst ? STALL_NONE : stall_next;
    assign ex_mc_busy   = !rst && (state_reg != ST_IDLE);
    assign ex_mc_done   = !rst && (state_reg == ST_DONE);
    assign stall_cycles = stall_cycles_reg;

    // State, latency counter and saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            cnt_reg          <= '0;
            stall_cycles_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if ((stall_next != STALL_NONE) && (stall_cycles_reg != {CNT_W{1'b1}})) begin
                stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl.
// The stimulus process drives one cycle of inputs shortly after each rising
// edge. It computes the expected outputs from a cycle-level model of the op
// lifetime and pushes them into a queue. The monitor pops one entry on every
// falling edge and compares it with the DUT outputs.
module tb_pipeline_stall_ctrl;

    localparam int L     = 4;
    localparam int CNTW  = 4;
    localparam int SAT   = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            id_reg1_rd = 1'b0;
    logic [4:0]      id_reg1_addr = '0;
    logic            id_reg2_rd = 1'b0;
    logic [4:0]      id_reg2_addr = '0;
    logic            ex_is_load = 1'b0;
    logic [4:0]      ex_wrAddr = '0;
    logic            ex_mc_start = 1'b0;
    logic            mem_stall_req = 1'b0;
    logic [5:0]      stall;
    logic            ex_mc_busy;
    logic            ex_mc_done;
    logic [CNTW-1:0] stall_cycles;

    pipeline_stall_ctrl #(.MC_LATENCY(L), .CNT_W(CNTW)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_reg1_rd   (id_reg1_rd),
        .id_reg1_addr (id_reg1_addr),
        .id_reg2_rd   (id_reg2_rd),
        .id_reg2_addr (id_reg2_addr),
        .ex_is_load   (ex_is_load),
        .ex_wrAddr    (ex_wrAddr),
        .ex_mc_start  (ex_mc_start),
        .mem_stall_req(mem_stall_req),
        .stall        (stall),
        .ex_mc_busy   (ex_mc_busy),
        .ex_mc_done   (ex_mc_done),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [5:0] stall;
        logic       busy;
        logic       done;
        int         cycles;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_id  = 0;

    // Reference model state.
    // age is the number of unfrozen cycles since the op entered EX, or -1 when no op is active.
    // cnt_m is the expected stall_cycles register value.
    int age   = -1;
    int cnt_m = 0;

    task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Drive one cycle and push the expected response for that cycle.
    task automatic drive(input logic r, input logic r1rd, input logic [4:0] r1a,
                         input logic r2rd, input logic [4:0] r2a, input logic ld,
                         input logic [4:0] wa, input logic st, input logic mem);
        exp_t e;
        bit   active, hold, lu;
        @(posedge clk);
        #1;
        rst = r; id_reg1_rd = r1rd; id_reg1_addr = r1a; id_reg2_rd = r2rd;
        id_reg2_addr = r2a; ex_is_load = ld; ex_wrAddr = wa; ex_mc_start = st;
        mem_stall_req = mem;
        e.cyc    = cyc_id;
        e.cycles = cnt_m;
        cyc_id++;
        if (r) begin
            e.stall = 6'd0; e.busy = 1'b0; e.done = 1'b0;
            age   = -1;
            cnt_m = 0;
        end else begin
            active = (age >= 0);
            e.busy = active;
            e.done = active && (age == L - 1);
            // EX is occupied for cycles 0..L-2 of an op's life; cycle L-1 delivers the result.
            hold = (!active && st) || (active && age < L - 1);
            lu   = ld && (wa != 5'd0) && ((r1rd && r1a == wa) || (r2rd && r2a == wa));
            if (mem)       e.stall = 6'b011111;
            else if (hold) e.stall = 6'b001111;
            else if (lu)   e.stall = 6'b000111;
            else           e.stall = 6'b000000;
            if (!mem) begin
                if (!active && st) age = 1;
                else if (active)   age = (age == L - 1) ? -1 : age + 1;
            end
            if (e.stall != 6'd0 && cnt_m < SAT) cnt_m++;
        end
        sb_q.push_back(e);
    endtask

    task automatic idle();
        drive(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    endtask

    // Monitor: one comparison set per cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            $display("[TB] cyc %0d stall=%b busy=%b done=%b cycles=%0d (exp %b %b %b %0d)",
                     e.cyc, stall, ex_mc_busy, ex_mc_done, stall_cycles,
                     e.stall, e.busy, e.done, e.cycles);
            chk("stall", e.cyc, 32'(stall), 32'(e.stall));
            chk("ex_mc_busy", e.cyc, 32'(ex_mc_busy), 32'(e.busy));
            chk("ex_mc_done", e.cyc, 32'(ex_mc_done), 32'(e.done));
            chk("stall_cycles", e.cyc, 32'(stall_cycles), 32'(e.cycles));
        end
    end

    initial begin
        // Reset with every request input high.
        drive(1, 1, 5'd3, 1, 5'd3, 1, 5'd3, 1, 1);
        drive(1, 1, 5'd3, 1, 5'd3, 1, 5'd3, 1, 1);
        idle();
        // Load-use on rt, then the same stimulus targeting r0, then a hazard on rs.
        drive(0, 0, 5'd0, 1, 5'd5, 1, 5'd5, 0, 0);
        idle();
        drive(0, 0, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0);
        drive(0, 1, 5'd9, 0, 5'd0, 1, 5'd9, 0, 0);
        drive(0, 1, 5'd9, 0, 5'd9, 1, 5'd8, 0, 0);
        // Multi-cycle op without interference.
        drive(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0);
        repeat (5) idle();
        // Multi-cycle op with a two-cycle memory wait at t+1.
        drive(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0);
        drive(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1);
        drive(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1);
        repeat (4) idle();
        // Memory wait during a load-use hazard.
        drive(0, 1, 5'd7, 0, 5'd0, 1, 5'd7, 0, 1);
        // Reset in the middle of a multi-cycle op.
        drive(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0);
        drive(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
        repeat (4) idle();
        // Saturation: twenty stalled cycles with a 4-bit counter.
        repeat (20) drive(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1);
        repeat (2) idle();
        // Randomized traffic with small register addresses to provoke hazards.
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 39) == 0),
                  1'($urandom), 5'($urandom_range(0, 3)),
                  1'($urandom), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0));
        end
        idle();
        repeat (3) @(negedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
